// File: rtl/l1_fill_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : l1_fill_responder_if
//  Description : Bundles the icache refill port and the backing-memory read
//                port of the L1 fill responder.
//                  l1_mmu_req_read   requester -> responder  refill request (level)
//                  l1_mmu_req_addr   requester -> responder  request byte address
//                  mmu_l1_done       responder -> requester  one-cycle done pulse
//                  mmu_l1_read_data  responder -> requester  256-bit line / MMIO word
//                  mem_rd            responder -> memory     one-cycle beat read pulse
//                  mem_addr          responder -> memory     beat word address
//                  mem_rvalid        memory    -> responder  beat data valid
//                  mem_rdata         memory    -> responder  beat data
//                Modport slave is the responder view; master is the
//                environment (icache + memory fabric) view.
//  Revision    : 1.0  initial release
// ============================================================================
interface l1_fill_responder_if;
    logic           l1_mmu_req_read;
    logic [31:0]    l1_mmu_req_addr;
    logic           mmu_l1_done;
    logic [255:0]   mmu_l1_read_data;
    logic           mem_rd;
    logic [31:0]    mem_addr;
    logic           mem_rvalid;
    logic [31:0]    mem_rdata;

    modport slave (
        input  l1_mmu_req_read,
        input  l1_mmu_req_addr,
        input  mem_rvalid,
        input  mem_rdata,
        output mmu_l1_done,
        output mmu_l1_read_data,
        output mem_rd,
        output mem_addr
    );

    modport master (
        output l1_mmu_req_read,
        output l1_mmu_req_addr,
        output mem_rvalid,
        output mem_rdata,
        input  mmu_l1_done,
        input  mmu_l1_read_data,
        input  mem_rd,
        input  mem_addr
    );
endinterface
`default_nettype wire

// File: rtl/l1_fill_responder.sv
`default_nettype none
// ============================================================================
//  Module      : l1_fill_responder
//  Description : MMU-side responder for the L1 icache refill port. A cacheable
//                request is served as eight ascending 32-bit beats assembled
//                into a 256-bit line; an MMIO request is a single word read
//                returned in bits [31:0]. Completion is a one-cycle done pulse,
//                followed by HOLD_CYCLES cycles in which the request is ignored.
//  Ports       : sys_clk  - system clock, all state on posedge
//                rst_n    - asynchronous active-low reset
//                bus      - refill/memory interface (slave modport)
//  Parameters  : HOLD_CYCLES - post-done request blanking, 1..3 cycles
//  Revision    : 1.0  initial release
// ============================================================================
module l1_fill_responder #(
    parameter int unsigned HOLD_CYCLES = 1
) (
    input  wire logic           sys_clk,
    input  wire logic           rst_n,
    l1_fill_responder_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_HOLD  = 3'd4
    } state_t;

    localparam logic [2:0] LAST_BEAT = 3'd7;
    localparam logic [1:0] HOLD_LAST = 2'(HOLD_CYCLES - 1);

    // MMIO window decoder: the top 256 MiB of the address map is MMIO.
    function automatic logic mmio_addr(input logic [3:0] addr_top);
        return (addr_top == 4'hF);
    endfunction

    state_t         state_q, state_d;
    logic [31:2]    a_q, a_d;
    logic           is_mmio_q, is_mmio_d;
    logic [2:0]     beat_q, beat_d;
    logic [1:0]     hold_q, hold_d;
    logic [255:0]   line_q, line_d;

    // Byte offset within the word never affects a word-granular fetch.
    logic           unused_addr_bits;
    assign unused_addr_bits = ^bus.l1_mmu_req_addr[1:0];

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            a_q       <= '0;
            is_mmio_q <= 1'b0;
            beat_q    <= '0;
            hold_q    <= '0;
            line_q    <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            is_mmio_q <= is_mmio_d;
            beat_q    <= beat_d;
            hold_q    <= hold_d;
            line_q    <= line_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        is_mmio_d = is_mmio_q;
        beat_d    = beat_q;
        hold_d    = hold_q;
        line_d    = line_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.l1_mmu_req_read) begin
                    a_d       = bus.l1_mmu_req_addr[31:2];
                    is_mmio_d = mmio_addr(bus.l1_mmu_req_addr[31:28]);
                    beat_d    = '0;
                    state_d   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.mem_rvalid) begin
                    if (is_mmio_q) begin
                        line_d = {224'b0, bus.mem_rdata};
                    end else begin
                        line_d[{beat_q, 5'd0} +: 32] = bus.mem_rdata;
                    end
                    if (is_mmio_q || (beat_q == LAST_BEAT)) begin
                        state_d = ST_DONE;
                    end else begin
                        beat_d  = beat_q + 3'd1;
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_DONE: begin
                hold_d  = '0;
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                // Absorbs a requester that drops its registered request late.
                if (hold_q == HOLD_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    hold_d = hold_q + 2'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Moore outputs decoded from registered state only. mem_addr is derived
    // from the latched address and beat, so it is stable across ISSUE/WAIT.
    assign bus.mmu_l1_done      = (state_q == ST_DONE);
    assign bus.mmu_l1_read_data = line_q;
    assign bus.mem_rd           = (state_q == ST_ISSUE);
    assign bus.mem_addr         = is_mmio_q ? {a_q[31:2], 2'b00}
                                            : {a_q[31:5], beat_q, 2'b00};

endmodule
`default_nettype wire

// File: tb/tb_l1_fill_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_l1_fill_responder
//  Description : Self-checking bench for l1_fill_responder. Acts as icache
//                requester and as a variable-latency memory, predicting the
//                beat address sequence, done cycle and returned line.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_l1_fill_responder;

    localparam int HOLD = 1;
    localparam int BUDGET = 400;

    logic sys_clk = 1'b0;
    logic rst_n   = 1'b0;
    always #5 sys_clk = ~sys_clk;

    l1_fill_responder_if bus();

    l1_fill_responder #(.HOLD_CYCLES(HOLD)) dut (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    int n_pass   = 0;
    int n_fail   = 0;
    int n_checks = 0;

    int          lat_a [8];
    logic [31:0] dat_a [8];

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit is_mmio(input logic [31:0] a);
        return a >= 32'hF000_0000;
    endfunction

    // One complete refill as seen from outside. chg_beat: beat at whose
    // issue the request address is changed. rst_beat: beat in whose WAIT
    // reset is asserted (transaction then aborts). -1 disables either.
    task automatic run_txn(input string nm, input logic [31:0] addr,
                           input int chg_beat, input logic [31:0] chg_addr,
                           input int rst_beat);
        bit           mmio;
        int           nbeats;
        int           exp_cycle;
        logic [255:0] exp_line;
        int           issued;
        int           cd;
        bit           done_seen;
        logic [31:0]  exp_addr;

        mmio      = is_mmio(addr);
        nbeats    = mmio ? 1 : 8;
        exp_line  = '0;
        exp_cycle = 1;
        for (int k = 0; k < nbeats; k++) begin
            exp_line[32*k +: 32] = dat_a[k];
            exp_cycle += 1 + lat_a[k];
        end
        issued    = 0;
        cd        = 0;
        done_seen = 1'b0;

        @(negedge sys_clk);
        bus.l1_mmu_req_addr = addr;
        bus.l1_mmu_req_read = 1'b1;

        for (int cyc = 1; cyc <= BUDGET; cyc++) begin
            @(negedge sys_clk);
            if (rst_beat >= 0 && issued == rst_beat + 1) begin
                rst_n               = 1'b0;
                bus.mem_rvalid      = 1'b0;
                bus.l1_mmu_req_read = 1'b0;
                #1;
                chk({nm, " rst_done"}, bus.mmu_l1_done, 1'b0);
                chk({nm, " rst_data"}, bus.mmu_l1_read_data, '0);
                chk({nm, " rst_rd"},   bus.mem_rd, 1'b0);
                chk({nm, " rst_addr"}, bus.mem_addr, '0);
                @(negedge sys_clk);
                rst_n = 1'b1;
                @(negedge sys_clk);
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata  = $urandom;
                @(negedge sys_clk);
                bus.mem_rvalid = 1'b0;
                chk({nm, " late_rv_done"}, bus.mmu_l1_done, 1'b0);
                chk({nm, " late_rv_data"}, bus.mmu_l1_read_data, '0);
                chk({nm, " late_rv_rd"},   bus.mem_rd, 1'b0);
                return;
            end
            bus.mem_rvalid = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    bus.mem_rvalid = 1'b1;
                    bus.mem_rdata  = dat_a[issued-1];
                end
            end
            if (bus.mem_rd) begin
                exp_addr = mmio ? (addr & 32'hFFFF_FFFC)
                                : (addr & 32'hFFFF_FFE0) + 32'(4 * issued);
                chk({nm, " beat_addr"}, bus.mem_addr, exp_addr);
                chk({nm, " one_outstanding"}, cd, 0);
                if (issued < 8) cd = lat_a[issued];
                if (issued == chg_beat) bus.l1_mmu_req_addr = chg_addr;
                issued++;
            end
            if (bus.mmu_l1_done) begin
                chk({nm, " done_cycle"}, cyc, exp_cycle);
                chk({nm, " line"}, bus.mmu_l1_read_data, exp_line);
                chk({nm, " beats"}, issued, nbeats);
                done_seen = 1'b1;
                break;
            end
        end
        chk({nm, " done_seen"}, done_seen, 1'b1);

        // Request stays up one more cycle, stray rvalids hit HOLD and IDLE.
        for (int k = 1; k <= 5; k++) begin
            @(negedge sys_clk);
            if (k == 2) bus.l1_mmu_req_read = 1'b0;
            bus.mem_rvalid = (k == 1 || k == 4);
            bus.mem_rdata  = $urandom;
            chk({nm, " post_rd"},   bus.mem_rd, 1'b0);
            chk({nm, " post_done"}, bus.mmu_l1_done, 1'b0);
            chk({nm, " post_data"}, bus.mmu_l1_read_data, exp_line);
        end
        bus.mem_rvalid = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        bus.l1_mmu_req_read = 1'b0;
        bus.l1_mmu_req_addr = '0;
        bus.mem_rvalid      = 1'b0;
        bus.mem_rdata       = '0;

        repeat (3) @(negedge sys_clk);
        chk("reset_done", bus.mmu_l1_done, 1'b0);
        chk("reset_data", bus.mmu_l1_read_data, '0);
        chk("reset_rd",   bus.mem_rd, 1'b0);
        chk("reset_addr", bus.mem_addr, '0);
        rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);

        for (int i = 0; i < 8; i++) begin
            lat_a[i] = 1;
            dat_a[i] = 32'hA000_0000 + 32'(i);
        end
        run_txn("fill_l1", 32'h0000_1234, -1, '0, -1);

        lat_a = '{3, 1, 5, 1, 2, 1, 1, 4};
        for (int i = 0; i < 8; i++) dat_a[i] = $urandom;
        run_txn("var_lat", 32'h0012_3458, -1, '0, -1);

        lat_a[0] = 1;
        dat_a[0] = 32'hDEAD_BEEF;
        run_txn("mmio", 32'hF000_0106, -1, '0, -1);

        for (int i = 0; i < 8; i++) begin
            lat_a[i] = int'($urandom_range(1, 3));
            dat_a[i] = $urandom;
        end
        run_txn("addr_chg", 32'h0000_8A40, 3, 32'h0000_4000, -1);

        for (int i = 0; i < 8; i++) lat_a[i] = 2;
        run_txn("rst_mid", 32'h0000_2200, -1, '0, 4);

        for (int i = 0; i < 8; i++) begin
            lat_a[i] = 1;
            dat_a[i] = $urandom;
        end
        run_txn("after_rst", 32'h0000_2200, -1, '0, -1);

        for (int t = 0; t < 6; t++) begin
            a = $urandom;
            a = ($urandom_range(0, 2) == 0) ? (a | 32'hF000_0000) : (a & 32'h7FFF_FFFF);
            for (int i = 0; i < 8; i++) begin
                lat_a[i] = int'($urandom_range(1, 5));
                dat_a[i] = $urandom;
            end
            run_txn("rand", a, -1, '0, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
